// File: rtl/prog_loader.sv
// Host-driven loader: parses a 32-bit command stream to fill instruction/data
// memory, run the CPU for a fixed cycle count, or stream data memory back out.
module prog_loader #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              cpu_enable,
  output logic [31:0]       imem_addr,
  output logic              imem_wen,
  output logic              imem_ren,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [31:0]       dmem_addr,
  output logic              dmem_wen,
  output logic              dmem_ren,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              busy,
  output logic              cmd_done
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    CMD_LOAD_I = 2'b00,
    CMD_LOAD_D = 2'b01,
    CMD_RUN    = 2'b10,
    CMD_DUMP_D = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RD,
    S_WAIT,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [13:0]         n_q, n_d;
  logic [15:0]         base_q, base_d;
  logic [13:0]         i_q, i_d;
  logic [29:0]         run_cnt_q, run_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic                cpu_enable_d, imem_wen_d, dmem_wen_d, dmem_ren_d;
  logic                busy_d, cmd_done_d;
  logic [31:0]         imem_addr_d, dmem_addr_d;
  logic [DATA_W-1:0]   imem_wdata_d, dmem_wdata_d, m_data_d;

  logic                s_fire, m_fire;
  cmd_t                hdr_cmd;
  logic [13:0]         hdr_n;
  logic [15:0]         hdr_b;
  logic [29:0]         hdr_c;

  function automatic logic [31:0] word_addr(input logic [15:0] b, input logic [13:0] i);
    logic [15:0] idx;
    idx = b + {2'b00, i};
    return {14'b0, idx, 2'b00};
  endfunction

  // s_ready is also gated by rst so every output reads 0 while reset is held.
  assign s_ready  = !rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign m_valid  = (state_q == S_OUT);
  assign imem_ren = 1'b0;

  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;
  assign hdr_cmd = cmd_t'(s_data[31:30]);
  assign hdr_n   = s_data[29:16];
  assign hdr_b   = s_data[15:0];
  assign hdr_c   = s_data[29:0];

  always_comb begin
    // NOTE: every signal driven here is defaulted first so no path infers a latch.
    state_d      = state_q;
    cmd_d        = cmd_q;
    n_d          = n_q;
    base_d       = base_q;
    i_d          = i_q;
    run_cnt_d    = run_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    cpu_enable_d = 1'b0;
    imem_wen_d   = 1'b0;
    dmem_wen_d   = 1'b0;
    dmem_ren_d   = 1'b0;
    cmd_done_d   = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    m_data_d     = m_data;

    unique case (state_q)
      S_IDLE: begin
        if (s_fire) begin
          cmd_d  = hdr_cmd;
          n_d    = hdr_n;
          base_d = hdr_b;
          i_d    = '0;
          unique case (hdr_cmd)
            CMD_RUN: begin
              if (hdr_c == '0) begin
                cmd_done_d = 1'b1;
              end else begin
                state_d      = S_RUN;
                cpu_enable_d = 1'b1;
                run_cnt_d    = hdr_c;
              end
            end
            CMD_DUMP_D: begin
              if (hdr_n == '0) begin
                cmd_done_d = 1'b1;
              end else begin
                state_d     = S_RD;
                dmem_ren_d  = 1'b1;
                dmem_addr_d = word_addr(hdr_b, 14'd0);
              end
            end
            default: begin
              if (hdr_n == '0) cmd_done_d = 1'b1;
              else             state_d    = S_LOAD;
            end
          endcase
        end
      end

      S_LOAD: begin
        if (s_fire) begin
          if (cmd_q == CMD_LOAD_I) begin
            imem_wen_d   = 1'b1;
            imem_addr_d  = word_addr(base_q, i_q);
            imem_wdata_d = s_data;
          end else begin
            dmem_wen_d   = 1'b1;
            dmem_addr_d  = word_addr(base_q, i_q);
            dmem_wdata_d = s_data;
          end
          i_d = i_q + 14'd1;
          if (i_q == n_q - 14'd1) begin
            state_d    = S_IDLE;
            cmd_done_d = 1'b1;
          end
        end
      end

      // The counter holds the cycles still owed, including the current one.
      S_RUN: begin
        if (run_cnt_q == 30'd1) begin
          state_d    = S_IDLE;
          cmd_done_d = 1'b1;
        end else begin
          cpu_enable_d = 1'b1;
          run_cnt_d    = run_cnt_q - 30'd1;
        end
      end

      S_RD: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end

      S_WAIT: begin
        if (wait_cnt_q == WAIT_W'(RD_LAT - 1)) begin
          m_data_d = dmem_rdata;
          state_d  = S_OUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_OUT: begin
        if (m_fire) begin
          i_d = i_q + 14'd1;
          if (i_q == n_q - 14'd1) begin
            state_d    = S_IDLE;
            cmd_done_d = 1'b1;
          end else begin
            state_d     = S_RD;
            dmem_ren_d  = 1'b1;
            dmem_addr_d = word_addr(base_q, i_q + 14'd1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_LOAD_I;
      n_q        <= '0;
      base_q     <= '0;
      i_q        <= '0;
      run_cnt_q  <= '0;
      wait_cnt_q <= '0;
      cpu_enable <= 1'b0;
      imem_wen   <= 1'b0;
      dmem_wen   <= 1'b0;
      dmem_ren   <= 1'b0;
      busy       <= 1'b0;
      cmd_done   <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      m_data     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      n_q        <= n_d;
      base_q     <= base_d;
      i_q        <= i_d;
      run_cnt_q  <= run_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      cpu_enable <= cpu_enable_d;
      imem_wen   <= imem_wen_d;
      dmem_wen   <= dmem_wen_d;
      dmem_ren   <= dmem_ren_d;
      busy       <= busy_d;
      cmd_done   <= cmd_done_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      m_data     <= m_data_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: memory-write scoreboard, run timing,
// dump with backpressure, and reset in the middle of a load.
module tb_prog_loader;

  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              cpu_enable;
  logic [31:0]       imem_addr, dmem_addr;
  logic              imem_wen, imem_ren, dmem_wen, dmem_ren;
  logic [DATA_W-1:0] imem_wdata, dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata = '0;
  logic              busy, cmd_done;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_m[$];
  logic [31:0] dmem_mem [0:65535];
  int          total = 0;
  int          bad = 0;

  prog_loader #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_enable(cpu_enable),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .busy(busy), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  // Data memory with a one-cycle registered read port.
  always @(posedge clk) begin
    if (dmem_wen) dmem_mem[dmem_addr[17:2]] <= dmem_wdata;
    if (dmem_ren) dmem_rdata <= dmem_mem[dmem_addr[17:2]];
  end

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    wr_t         e;
    logic [31:0] a, d;
    if (imem_wen || dmem_wen) begin
      total++;
      if (cpu_enable !== 1'b0) begin
        bad++;
        $display("FAIL enable_during_write: cpu_enable=%b required 0", cpu_enable);
      end
      total++;
      if (imem_wen && dmem_wen) begin
        bad++;
        $display("FAIL dual_write: both strobes high at %0t", $time);
      end else if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL spurious_write: imem_wen=%b dmem_wen=%b addr=%h at %0t",
                 imem_wen, dmem_wen, dmem_wen ? dmem_addr : imem_addr, $time);
      end else begin
        e = exp_wr.pop_front();
        a = dmem_wen ? dmem_addr : imem_addr;
        d = dmem_wen ? dmem_wdata : imem_wdata;
        if ({dmem_wen, a, d, cmd_done} !== {e.is_d, e.addr, e.data, e.last}) begin
          bad++;
          $display("FAIL write: got d=%b addr=%h data=%h done=%b required d=%b addr=%h data=%h done=%b",
                   dmem_wen, a, d, cmd_done, e.is_d, e.addr, e.data, e.last);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bit ok = 0;
    s_data  = w;
    s_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %h not accepted", w);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic push_wr(input logic is_d, input logic [31:0] addr, input logic [31:0] data,
                         input logic last);
    wr_t e;
    e.is_d = is_d; e.addr = addr; e.data = data; e.last = last;
    exp_wr.push_back(e);
  endtask

  task automatic check_drained(input string name);
    idle(3);
    total++;
    if (exp_wr.size() !== 0) begin
      bad++;
      $display("FAIL %s_drain: %0d writes missing, required 0", name, exp_wr.size());
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({s_ready, m_valid, cpu_enable, imem_wen, imem_ren, dmem_wen, dmem_ren, busy, cmd_done} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 000000000",
               {s_ready, m_valid, cpu_enable, imem_wen, imem_ren, dmem_wen, dmem_ren, busy, cmd_done});
    end
    total++;
    if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata, m_data} !== 160'b0) begin
      bad++;
      $display("FAIL reset_data: imem_addr=%h dmem_addr=%h m_data=%h required 0",
               imem_addr, dmem_addr, m_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({s_ready, busy, m_valid, cmd_done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_release: s_ready/busy/m_valid/cmd_done=%b required 1000",
               {s_ready, busy, m_valid, cmd_done});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_i();
    push_wr(1'b0, 32'h10, 32'h20080005, 1'b0);
    push_wr(1'b0, 32'h14, 32'h20090007, 1'b0);
    push_wr(1'b0, 32'h18, 32'h01095020, 1'b1);
    send(32'h0003_0004);
    send(32'h20080005);
    send(32'h20090007);
    send(32'h01095020);
    check_drained("load_i");
  endtask

  task automatic test_load_d_stall();
    push_wr(1'b1, 32'h0003FFFC, 32'hCAFE0001, 1'b0);
    push_wr(1'b1, 32'h00000000, 32'hCAFE0002, 1'b1);
    send(32'h4002_FFFF);
    idle(3);
    send(32'hCAFE0001);
    idle(3);
    send(32'hCAFE0002);
    check_drained("load_d");
  endtask

  // Cycle k after the header handshake: enable for k<c, done at k==c.
  task automatic test_run(input logic [29:0] c);
    logic [3:0] got, req;
    send({2'b10, c});
    for (int k = 0; k <= int'(c); k++) begin
      @(negedge clk);
      got = {cpu_enable, cmd_done, s_ready, busy};
      req = {k < int'(c), k == int'(c), k == int'(c), k < int'(c)};
      total++;
      if (got !== req) begin
        bad++;
        $display("FAIL run_c%0d_cycle%0d: en/done/s_ready/busy=%b required %b", c, k, got, req);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_dump();
    int h = 0;
    int stall = 0;
    int cyc = 0;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      dmem_mem[8 + i] = 32'hAAAA0000 + 32'(i);
      exp_m.push_back(32'hAAAA0000 + 32'(i));
    end
    m_ready = 1'b0;
    send(32'hC004_0008);
    while (h < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      total++;
      if (s_ready !== 1'b0) begin
        bad++;
        $display("FAIL dump_s_ready: s_ready=%b required 0", s_ready);
      end
      if (m_valid) begin
        if (h == 1 && stall < 5) begin
          m_ready = 1'b0;
          stall++;
          total++;
          if (m_data !== exp_m[0]) begin
            bad++;
            $display("FAIL dump_stall: m_data=%h required %h", m_data, exp_m[0]);
          end
        end else begin
          m_ready = 1'b1;
          e = exp_m.pop_front();
          total++;
          if (m_data !== e) begin
            bad++;
            $display("FAIL dump_word%0d: m_data=%h required %h", h, m_data, e);
          end
          h++;
        end
      end else begin
        m_ready = 1'b0;
        if (h == 1 && stall > 0) begin
          total++;
          bad++;
          $display("FAIL dump_valid_drop: m_valid=0 required 1 during stall");
        end
      end
    end
    if (h < 4) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: %0d handshakes required 4", h);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({cmd_done, m_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL dump_done: done/m_valid/busy=%b required 100", {cmd_done, m_valid, busy});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_load();
    push_wr(1'b0, 32'h80, 32'h11110000, 1'b0);
    push_wr(1'b0, 32'h84, 32'h11110001, 1'b0);
    send(32'h0005_0020);
    send(32'h11110000);
    send(32'h11110001);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h11110002;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({imem_wen, dmem_wen, busy, cmd_done, s_ready} !== 5'b0) begin
      bad++;
      $display("FAIL midrst_outputs: wen_i/wen_d/busy/done/s_ready=%b required 00000",
               {imem_wen, dmem_wen, busy, cmd_done, s_ready});
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    total++;
    if (exp_wr.size() !== 0) begin
      bad++;
      $display("FAIL midrst_pre_writes: %0d writes missing, required 0", exp_wr.size());
      exp_wr.delete();
    end
    push_wr(1'b1, 32'h400, 32'h12345678, 1'b1);
    send(32'h4001_0100);
    send(32'h12345678);
    check_drained("midrst");
  endtask

  task automatic test_back_to_back();
    push_wr(1'b1, 32'h800, 32'h0BADF00D, 1'b1);
    send(32'h4001_0200);
    send(32'h0BADF00D);
    test_run(30'd2);
    check_drained("b2b");
  endtask

  initial begin
    test_reset();
    test_load_i();
    test_load_d_stall();
    test_run(30'd10);
    test_run(30'd0);
    test_dump();
    test_back_to_back();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
